// File: rtl/branch_predictor.sv
// Bimodal BHT of 2-bit saturating counters with registered take_flag and mispredict counter.
// Define FCPU_BP_GHR_EN to XOR a global history register into the index (gshare).
module branch_predictor #(
  parameter int unsigned BHT_INDEX_W = 6,
  parameter int unsigned HIST_W      = 6,
  parameter int unsigned CRAM_ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   ce,
  input  logic [CRAM_ADDR_W-1:0] i_lookup_pc,
  input  logic                   i_lookup_valid,
  output logic                   take_flag,
  input  logic                   i_resolve_valid,
  input  logic [CRAM_ADDR_W-1:0] i_resolve_pc,
  input  logic                   i_resolve_taken,
  input  logic                   i_resolve_mispredict,
  output logic [31:0]            o_mispredict_count
);

  localparam int unsigned Entries = 2 ** BHT_INDEX_W;

  logic [1:0]             bht_q [Entries];
  logic [BHT_INDEX_W-1:0] lookup_idx;
  logic [BHT_INDEX_W-1:0] resolve_idx;
  logic [1:0]             resolve_cnt;
  logic [1:0]             resolve_cnt_next;
  logic [1:0]             lookup_cnt;
  logic                   take_q;
  logic                   take_d;
  logic [31:0]            mispredict_count_q;
  logic                   unused_pc;

  // Word-aligned PCs: bits [1:0] and bits above the index never select an entry.
  assign unused_pc = ^{i_lookup_pc, i_resolve_pc};

`ifdef FCPU_BP_GHR_EN
  logic [HIST_W-1:0]      ghr_q;
  logic [HIST_W-1:0]      ghr_d;
  logic [BHT_INDEX_W-1:0] ghr_ext;

  assign ghr_ext     = BHT_INDEX_W'(ghr_q);
  assign lookup_idx  = i_lookup_pc[2 +: BHT_INDEX_W] ^ ghr_ext;
  assign resolve_idx = i_resolve_pc[2 +: BHT_INDEX_W] ^ ghr_ext;

  always_comb begin
    ghr_d = ghr_q;
    if (i_resolve_valid) begin
      ghr_d = HIST_W'({ghr_q, i_resolve_taken});
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  logic [HIST_W-1:0] unused_hist;

  assign unused_hist = '0;
  assign lookup_idx  = i_lookup_pc[2 +: BHT_INDEX_W];
  assign resolve_idx = i_resolve_pc[2 +: BHT_INDEX_W];
`endif

  assign resolve_cnt = bht_q[resolve_idx];

  always_comb begin
    resolve_cnt_next = resolve_cnt;
    if (i_resolve_taken) begin
      if (resolve_cnt != 2'b11) begin
        resolve_cnt_next = resolve_cnt + 2'd1;
      end
    end else begin
      if (resolve_cnt != 2'b00) begin
        resolve_cnt_next = resolve_cnt - 2'd1;
      end
    end
  end

  // Write-first bypass: a same-index lookup sees the counter being written this cycle.
  always_comb begin
    lookup_cnt = bht_q[lookup_idx];
    if (i_resolve_valid && (resolve_idx == lookup_idx)) begin
      lookup_cnt = resolve_cnt_next;
    end
  end

  always_comb begin
    take_d = take_q;
    if (ce) begin
      take_d = i_lookup_valid & lookup_cnt[1];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < Entries; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (i_resolve_valid) begin
      bht_q[resolve_idx] <= resolve_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      take_q <= 1'b0;
    end else begin
      take_q <= take_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mispredict_count_q <= '0;
    end else if (i_resolve_valid && i_resolve_mispredict && (mispredict_count_q != '1)) begin
      mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign take_flag          = take_q;
  assign o_mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic
// compared against an array-based reference model of the counter table.
module tb_branch_predictor;

  logic        clk;
  logic        nrst;
  logic        ce;
  logic [15:0] i_lookup_pc;
  logic        i_lookup_valid;
  logic        take_flag;
  logic        i_resolve_valid;
  logic [15:0] i_resolve_pc;
  logic        i_resolve_taken;
  logic        i_resolve_mispredict;
  logic [31:0] o_mispredict_count;

  int unsigned n_checks;
  int unsigned n_fail;

  int unsigned mdl_bht [64];
  int unsigned mdl_ghr;
  logic        exp_take;
  logic [31:0] exp_cnt;

  branch_predictor #(
    .BHT_INDEX_W(6),
    .HIST_W     (6),
    .CRAM_ADDR_W(16)
  ) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .ce                  (ce),
    .i_lookup_pc         (i_lookup_pc),
    .i_lookup_valid      (i_lookup_valid),
    .take_flag           (take_flag),
    .i_resolve_valid     (i_resolve_valid),
    .i_resolve_pc        (i_resolve_pc),
    .i_resolve_taken     (i_resolve_taken),
    .i_resolve_mispredict(i_resolve_mispredict),
    .o_mispredict_count  (o_mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned mdl_idx(input logic [15:0] pc);
    int unsigned idx;
    idx = (int'(pc) / 4) % 64;
`ifdef FCPU_BP_GHR_EN
    idx = idx ^ mdl_ghr;
`endif
    return idx;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 64; i++) mdl_bht[i] = 1;
    mdl_ghr  = 0;
    exp_take = 1'b0;
    exp_cnt  = 32'd0;
  endtask

  // Apply one clock of stimulus, advance the model, then compare both outputs.
  task automatic cyc(input logic lv, input logic [15:0] lpc, input logic rv,
                     input logic [15:0] rpc, input logic rt, input logic rm, input logic c);
    int unsigned li;
    int unsigned ri;
    @(negedge clk);
    i_lookup_valid       = lv;
    i_lookup_pc          = lpc;
    i_resolve_valid      = rv;
    i_resolve_pc         = rpc;
    i_resolve_taken      = rt;
    i_resolve_mispredict = rm;
    ce                   = c;
    @(posedge clk);
    li = mdl_idx(lpc);
    ri = mdl_idx(rpc);
    if (rv) begin
      if (rt) mdl_bht[ri] = (mdl_bht[ri] < 3) ? mdl_bht[ri] + 1 : 3;
      else    mdl_bht[ri] = (mdl_bht[ri] > 0) ? mdl_bht[ri] - 1 : 0;
      if (rm && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      mdl_ghr = ((mdl_ghr * 2) + (rt ? 1 : 0)) % 64;
    end
    if (c) exp_take = lv && (mdl_bht[li] >= 2);
    #1;
    check_eq("take_flag", {31'd0, take_flag}, {31'd0, exp_take});
    check_eq("mispredict_count", o_mispredict_count, exp_cnt);
  endtask

  task automatic lookup(input logic [15:0] pc);
    cyc(1'b1, pc, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic resolve(input logic [15:0] pc, input logic taken, input logic mis);
    cyc(1'b0, 16'h0, 1'b1, pc, taken, mis, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nrst = 1'b0;
    ce = 1'b1;
    i_lookup_valid = 1'b0;
    i_lookup_pc = '0;
    i_resolve_valid = 1'b0;
    i_resolve_pc = '0;
    i_resolve_taken = 1'b0;
    i_resolve_mispredict = 1'b0;
    mdl_reset();
    #2;
    check_eq("reset_take", {31'd0, take_flag}, 32'd0);
    check_eq("reset_count", o_mispredict_count, 32'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;

`ifndef FCPU_BP_GHR_EN
    // Training to strong-T, then down to strong-NT and held there.
    resolve(16'h0040, 1'b1, 1'b0);
    resolve(16'h0040, 1'b1, 1'b1);
    lookup(16'h0040);
    check_eq("train_taken", {31'd0, take_flag}, 32'd1);
    for (int i = 0; i < 5; i++) resolve(16'h0040, 1'b0, 1'b0);
    lookup(16'h0040);
    check_eq("train_nt", {31'd0, take_flag}, 32'd0);
    resolve(16'h0040, 1'b1, 1'b0);
    lookup(16'h0040);
    check_eq("sat_floor_step1", {31'd0, take_flag}, 32'd0);
    resolve(16'h0040, 1'b1, 1'b0);
    lookup(16'h0040);
    check_eq("sat_floor_step2", {31'd0, take_flag}, 32'd1);

    // Same-cycle resolve and lookup of a weak-NT entry.
    cyc(1'b1, 16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b1);
    check_eq("bypass", {31'd0, take_flag}, 32'd1);

    // Halt: take_flag holds while a resolve still trains the table.
    cyc(1'b1, 16'h0020, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0020, 1'b1, 16'h0020, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 16'h0020, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check_eq("halt_hold", {31'd0, take_flag}, 32'd1);
    lookup(16'h0020);
    check_eq("halt_update", {31'd0, take_flag}, 32'd1);

    // Aliasing across the upper PC bits.
    resolve(16'h0000, 1'b1, 1'b0);
    resolve(16'h0000, 1'b1, 1'b0);
    lookup(16'h0100);
    check_eq("alias", {31'd0, take_flag}, 32'd1);
`else
    // GHR=1 steers pc 0x80 onto the entry trained by pc 0x84 under GHR=0.
    resolve(16'h0084, 1'b1, 1'b0);
    lookup(16'h0080);
    check_eq("ghr_distinct_a", {31'd0, take_flag}, 32'd1);
    lookup(16'h0084);
    check_eq("ghr_distinct_b", {31'd0, take_flag}, 32'd0);
`endif

    // Mispredict counter saturation.
    force dut.mispredict_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispredict_count_q;
    exp_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) resolve(16'h0004, 1'b0, 1'b1);
    check_eq("count_sat", o_mispredict_count, 32'hFFFF_FFFF);

    // Mid-run asynchronous reset with a trained table and take_flag high.
    resolve(16'h0000, 1'b1, 1'b0);
    resolve(16'h0000, 1'b1, 1'b0);
    lookup(16'h0000);
    check_eq("pre_reset_take", {31'd0, take_flag}, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check_eq("async_reset_take", {31'd0, take_flag}, 32'd0);
    check_eq("async_reset_count", o_mispredict_count, 32'd0);
    mdl_reset();
    @(negedge clk);
    nrst = 1'b1;
    lookup(16'h0000);
    check_eq("post_reset_0000", {31'd0, take_flag}, 32'd0);
    lookup(16'h0040);
    check_eq("post_reset_0040", {31'd0, take_flag}, 32'd0);

    // Random traffic on a small index set so bypass and aliasing occur often.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] lpc;
      logic [15:0] rpc;
      lpc = 16'(($urandom_range(0, 15) * 4) + ($urandom_range(0, 3) * 256));
      rpc = 16'(($urandom_range(0, 15) * 4) + ($urandom_range(0, 3) * 256));
      cyc($urandom_range(0, 3) != 0, lpc, $urandom_range(0, 1) != 0, rpc,
          $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 4) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
